// File: rtl/account_access_arbiter_pkg.sv
// Shared opcode, status and FSM state types for the account access arbiter.
package account_access_arbiter_pkg;

    typedef enum logic [1:0] {
        OP_OPEN    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_RELEASE = 2'b10,
        OP_RSVD    = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK        = 2'b00,
        ST_LOCKED    = 2'b01,
        ST_NOT_OWNER = 2'b10,
        ST_BAD_OP    = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_RESP   = 2'b10
    } state_e;

    // Outcome of a request given the lock entry of its card.
    // 'owned' is only true when the entry is valid and belongs to the requester.
    function automatic status_e decide_status(input op_e op, input logic lk_valid, input logic owned);
        status_e st;
        case (op)
            OP_OPEN:              st = (!lk_valid || owned) ? ST_OK : ST_LOCKED;
            OP_WRITE, OP_RELEASE: st = owned ? ST_OK : ST_NOT_OWNER;
            default:              st = ST_BAD_OP;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/account_access_arbiter_if.sv
// Terminal-side request/response bus of the account access arbiter.
interface account_access_arbiter_if #(
    parameter int NUM_ATM       = 4,
    parameter int CARD_WIDTH    = 6,
    parameter int BALANCE_WIDTH = 20
);
    logic [NUM_ATM-1:0]               req_valid;
    logic [2*NUM_ATM-1:0]             req_op;
    logic [CARD_WIDTH*NUM_ATM-1:0]    req_card;
    logic [BALANCE_WIDTH*NUM_ATM-1:0] req_wdata;
    logic [NUM_ATM-1:0]               abort;
    logic [NUM_ATM-1:0]               resp_valid;
    logic [1:0]                       resp_status;
    logic [BALANCE_WIDTH-1:0]         resp_rdata;

    // Terminal side
    modport master (
        output req_valid, req_op, req_card, req_wdata, abort,
        input  resp_valid, resp_status, resp_rdata
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_op, req_card, req_wdata, abort,
        output resp_valid, resp_status, resp_rdata
    );
endinterface

// File: rtl/account_access_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches from ptr+1 upward (wrapping), one-hot grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant
);
    localparam int          PW = $clog2(NUM_REQ);
    localparam int unsigned N  = NUM_REQ;

    logic          found;
    logic [PW-1:0] idx;

    // First requester after the last granted one wins; ptr itself is checked last.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = PW'((32'(ptr) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/account_access_arbiter.sv
// Shares one single-port balance RAM among NUM_ATM terminals with round-robin
// arbitration and a per-card session lock table.
module account_access_arbiter
    import account_access_arbiter_pkg::*;
#(
    parameter int NUM_ATM       = 4,
    parameter int CARD_WIDTH    = 6,
    parameter int BALANCE_WIDTH = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    account_access_arbiter_if.slave  term,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [CARD_WIDTH-1:0]    mem_addr,
    output logic [BALANCE_WIDTH-1:0] mem_wdata,
    input  logic [BALANCE_WIDTH-1:0] mem_rdata
);
    localparam int          OW    = $clog2(NUM_ATM);
    localparam int unsigned N     = NUM_ATM;
    localparam int unsigned DEPTH = 1 << CARD_WIDTH;

    state_e                   state;
    logic [OW-1:0]            rr_ptr;
    logic [NUM_ATM-1:0]       grant;

    // Fields of the currently granted requester (IDLE cycle only)
    logic [OW-1:0]            g_idx_c;
    op_e                      op_c;
    logic [CARD_WIDTH-1:0]    card_c;
    logic [BALANCE_WIDTH-1:0] wdata_c;
    logic                     lk_valid_c;
    logic                     lk_owned_c;
    status_e                  status_c;
    logic                     mem_access_c;

    // Latched transaction
    logic [OW-1:0]            g_idx;
    op_e                      cur_op;
    logic [CARD_WIDTH-1:0]    cur_card;
    status_e                  cur_status;

    // Registered response
    logic [NUM_ATM-1:0]       resp_valid_q;
    status_e                  resp_status_q;
    logic                     rdata_sel;

    // Lock table
    logic [DEPTH-1:0]         lock_valid;
    logic [OW-1:0]            lock_owner [DEPTH];
    logic                     lock_set;

    rr_arbiter #(.NUM_REQ(NUM_ATM)) u_rr (
        .req   (term.req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Select the granted requester's fields and evaluate the lock entry for its card.
    always_comb begin
        g_idx_c = '0;
        op_c    = OP_OPEN;
        card_c  = '0;
        wdata_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) begin
                g_idx_c = OW'(i);
                op_c    = op_e'(term.req_op[2*i +: 2]);
                card_c  = term.req_card[CARD_WIDTH*i +: CARD_WIDTH];
                wdata_c = term.req_wdata[BALANCE_WIDTH*i +: BALANCE_WIDTH];
            end
        end
        lk_valid_c   = lock_valid[card_c];
        lk_owned_c   = lk_valid_c && (lock_owner[card_c] == g_idx_c);
        status_c     = decide_status(op_c, lk_valid_c, lk_owned_c);
        mem_access_c = (status_c == ST_OK) && ((op_c == OP_OPEN) || (op_c == OP_WRITE));
    end

    // Status is resolved on the granting edge so the memory strobe can be
    // registered and still be high for exactly the ACCESS cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            rr_ptr        <= '0;
            g_idx         <= '0;
            cur_op        <= OP_OPEN;
            cur_card      <= '0;
            cur_status    <= ST_OK;
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            resp_valid_q  <= '0;
            resp_status_q <= ST_OK;
            rdata_sel     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|term.req_valid) begin
                        g_idx      <= g_idx_c;
                        cur_op     <= op_c;
                        cur_card   <= card_c;
                        cur_status <= status_c;
                        mem_en     <= mem_access_c;
                        mem_we     <= mem_access_c && (op_c == OP_WRITE);
                        mem_addr   <= mem_access_c ? card_c : '0;
                        mem_wdata  <= (mem_access_c && (op_c == OP_WRITE)) ? wdata_c : '0;
                        state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    mem_en        <= 1'b0;
                    mem_we        <= 1'b0;
                    mem_addr      <= '0;
                    mem_wdata     <= '0;
                    resp_valid_q  <= NUM_ATM'(1) << g_idx;
                    resp_status_q <= cur_status;
                    rdata_sel     <= (cur_op == OP_OPEN) && (cur_status == ST_OK);
                    state         <= S_RESP;
                end
                S_RESP: begin
                    resp_valid_q  <= '0;
                    resp_status_q <= ST_OK;
                    rdata_sel     <= 1'b0;
                    rr_ptr        <= g_idx;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // An abort from the granted terminal suppresses its own lock set.
    assign lock_set = (state == S_RESP) && (cur_status == ST_OK) && (cur_op == OP_OPEN)
                      && !term.abort[g_idx];

    // Lock table: OPEN sets, RELEASE clears, abort drops every entry owned by the aborting terminal.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_valid <= '0;
            for (int unsigned d = 0; d < DEPTH; d++) begin
                lock_owner[d] <= '0;
            end
        end else begin
            if (lock_set) begin
                lock_valid[cur_card] <= 1'b1;
                lock_owner[cur_card] <= g_idx;
            end else if ((state == S_RESP) && (cur_status == ST_OK) && (cur_op == OP_RELEASE)) begin
                lock_valid[cur_card] <= 1'b0;
            end
            // The entry being newly set must not be cleared on behalf of its previous owner.
            for (int unsigned d = 0; d < DEPTH; d++) begin
                for (int unsigned a = 0; a < N; a++) begin
                    if (term.abort[a] && (lock_owner[d] == OW'(a))
                        && !(lock_set && (CARD_WIDTH'(d) == cur_card))) begin
                        lock_valid[d] <= 1'b0;
                    end
                end
            end
        end
    end

    assign term.resp_valid  = resp_valid_q;
    assign term.resp_status = resp_status_q;
    assign term.resp_rdata  = rdata_sel ? mem_rdata : '0;

endmodule

// File: tb/tb_account_access_arbiter.sv
// Directed test of account_access_arbiter against a simple synchronous RAM model.
module tb_account_access_arbiter;

    localparam int NA = 4;
    localparam int CW = 6;
    localparam int BW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_en;
    logic          mem_we;
    logic [CW-1:0] mem_addr;
    logic [BW-1:0] mem_wdata;
    logic [BW-1:0] mem_rdata = '0;
    logic          preload = 1'b1;
    logic [BW-1:0] mem [64];

    int n_pass  = 0;
    int n_total = 0;

    // Results of the most recent transaction
    int            r_lat;
    logic [1:0]    r_st;
    logic [BW-1:0] r_rd;
    logic [NA-1:0] r_rv;
    logic          r_en;
    logic          r_we;
    logic [BW-1:0] r_wd;
    logic [CW-1:0] r_addr;

    account_access_arbiter_if #(.NUM_ATM(NA), .CARD_WIDTH(CW), .BALANCE_WIDTH(BW)) term ();

    account_access_arbiter #(.NUM_ATM(NA), .CARD_WIDTH(CW), .BALANCE_WIDTH(BW)) dut (
        .clk       (clk),
        .rst       (rst),
        .term      (term),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM, read data valid the cycle after mem_en
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= BW'(i);
            mem[5]  <= 20'd1000;
            mem[9]  <= 20'd555;
            for (int i = 0; i < 4; i++) mem[20+i] <= BW'(100 + i);
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int oh_idx(input logic [NA-1:0] v);
        for (int i = 0; i < NA; i++) if (v[i]) return i;
        return 99;
    endfunction

    // One request from terminal a; optionally aborts during the response cycle.
    task automatic run_txn(input int a, input logic [1:0] op, input logic [CW-1:0] card,
                           input logic [BW-1:0] wd, input bit do_abort);
        int cyc;
        bit got;
        term.req_valid[a]         = 1'b1;
        term.req_op[2*a +: 2]     = op;
        term.req_card[CW*a +: CW] = card;
        term.req_wdata[BW*a +: BW] = wd;
        r_en = 1'b0; r_we = 1'b0; r_wd = '0; r_addr = '0;
        r_lat = 0; r_st = 2'b00; r_rd = '0; r_rv = '0;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
            if (mem_en) begin
                r_en = 1'b1; r_we = mem_we; r_wd = mem_wdata; r_addr = mem_addr;
            end
            if (term.resp_valid != '0) begin
                got = 1'b1; r_lat = cyc; r_rv = term.resp_valid;
                r_st = term.resp_status; r_rd = term.resp_rdata;
            end
        end
        term.req_valid[a] = 1'b0;
        if (do_abort) term.abort[a] = 1'b1;
        @(posedge clk); #1;
        term.abort = '0;
        if (!got) check("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_txn(input string tag, input int a, input logic [1:0] st,
                              input logic [BW-1:0] rd, input bit en, input bit we);
        check({tag, "_lat"}, r_lat, 2);
        check({tag, "_rv"}, r_rv, 32'(1 << a));
        check({tag, "_status"}, r_st, st);
        check({tag, "_rdata"}, r_rd, rd);
        check({tag, "_mem_en"}, r_en, en);
        check({tag, "_mem_we"}, r_we, we);
    endtask

    initial begin
        int order [4];
        int when  [4];
        logic [1:0]    st4 [4];
        logic [BW-1:0] rd4 [4];
        int got_n;
        int cyc;
        int idx;
        int exp_order [4] = '{1, 2, 3, 0};

        term.req_valid = '0;
        term.req_op    = '0;
        term.req_card  = '0;
        term.req_wdata = '0;
        term.abort     = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", term.resp_valid, 0);
        check("rst_resp_status", term.resp_status, 0);
        check("rst_resp_rdata", term.resp_rdata, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        rst = 1'b0;
        preload = 1'b0;
        @(posedge clk); #1;

        // 1: ATM0 opens card 5
        run_txn(0, 2'b00, 6'd5, '0, 1'b0);
        expect_txn("t1_open", 0, 2'b00, 20'd1000, 1'b1, 1'b0);
        check("t1_addr", r_addr, 5);

        // 2: ATM1 blocked by ATM0's lock
        run_txn(1, 2'b00, 6'd5, '0, 1'b0);
        expect_txn("t2_locked", 1, 2'b01, 20'd0, 1'b0, 1'b0);

        // 3: owner write succeeds, foreign write rejected
        run_txn(0, 2'b01, 6'd5, 20'd700, 1'b0);
        expect_txn("t3_write_own", 0, 2'b00, 20'd0, 1'b1, 1'b1);
        check("t3_wdata", r_wd, 700);
        run_txn(1, 2'b01, 6'd5, 20'd1, 1'b0);
        expect_txn("t3_write_foreign", 1, 2'b10, 20'd0, 1'b0, 1'b0);
        check("t3_mem5", mem[5], 700);
        run_txn(0, 2'b00, 6'd5, '0, 1'b0);
        expect_txn("t3_reopen", 0, 2'b00, 20'd700, 1'b1, 1'b0);

        // Reserved op, foreign release, owner release (leaves pointer at 0)
        run_txn(2, 2'b11, 6'd5, '0, 1'b0);
        expect_txn("bad_op", 2, 2'b11, 20'd0, 1'b0, 1'b0);
        run_txn(1, 2'b10, 6'd5, '0, 1'b0);
        expect_txn("rel_foreign", 1, 2'b10, 20'd0, 1'b0, 1'b0);
        run_txn(0, 2'b10, 6'd5, '0, 1'b0);
        expect_txn("rel_own", 0, 2'b00, 20'd0, 1'b0, 1'b0);
        run_txn(1, 2'b00, 6'd5, '0, 1'b0);
        expect_txn("open_after_rel", 1, 2'b00, 20'd700, 1'b1, 1'b0);
        run_txn(1, 2'b10, 6'd5, '0, 1'b0);
        run_txn(0, 2'b10, 6'd6, '0, 1'b0);
        expect_txn("rel_free", 0, 2'b10, 20'd0, 1'b0, 1'b0);

        // 4: all four request together with pointer at 0
        for (int i = 0; i < 4; i++) begin
            order[i] = 99; when[i] = 0; st4[i] = 2'b11; rd4[i] = '0;
            term.req_valid[i]        = 1'b1;
            term.req_op[2*i +: 2]    = 2'b00;
            term.req_card[CW*i +: CW] = CW'(20 + i);
        end
        got_n = 0;
        cyc   = 0;
        while (got_n < 4 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (term.resp_valid != '0) begin
                idx = oh_idx(term.resp_valid);
                order[got_n] = idx;
                when[got_n]  = cyc;
                st4[got_n]   = term.resp_status;
                rd4[got_n]   = term.resp_rdata;
                term.req_valid = term.req_valid & ~term.resp_valid;
                got_n++;
            end
        end
        term.req_valid = '0;
        @(posedge clk); #1;
        check("t4_count", got_n, 4);
        check("t4_first_lat", when[0], 2);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t4_order%0d", k), order[k], exp_order[k]);
            check($sformatf("t4_status%0d", k), st4[k], 0);
            check($sformatf("t4_rdata%0d", k), rd4[k], 100 + exp_order[k]);
            if (k > 0) check($sformatf("t4_gap%0d", k), when[k] - when[k-1], 3);
        end

        // 5: abort coincides with ATM0's OPEN response
        run_txn(0, 2'b00, 6'd9, '0, 1'b1);
        expect_txn("t5_open_abort", 0, 2'b00, 20'd555, 1'b1, 1'b0);
        run_txn(2, 2'b00, 6'd9, '0, 1'b0);
        expect_txn("t5_atm2_open", 2, 2'b00, 20'd555, 1'b1, 1'b0);
        run_txn(1, 2'b00, 6'd9, '0, 1'b0);
        expect_txn("t5_atm1_locked", 1, 2'b01, 20'd0, 1'b0, 1'b0);
        run_txn(3, 2'b00, 6'd20, '0, 1'b0);
        expect_txn("t5_abort_freed20", 3, 2'b00, 20'd100, 1'b1, 1'b0);

        // 6: reset during ACCESS of a WRITE
        term.req_valid[2]         = 1'b1;
        term.req_op[2*2 +: 2]     = 2'b01;
        term.req_card[CW*2 +: CW] = 6'd9;
        term.req_wdata[BW*2 +: BW] = 20'd42;
        @(posedge clk); #1;
        check("t6_access_we", mem_we, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_rst_resp_valid", term.resp_valid, 0);
        check("t6_rst_mem_en", mem_en, 0);
        rst = 1'b0;
        term.req_valid = '0;
        @(posedge clk); #1;
        check("t6_post_resp_valid", term.resp_valid, 0);
        check("t6_post_mem_en", mem_en, 0);
        run_txn(1, 2'b00, 6'd9, '0, 1'b0);
        check("t6_lock9_cleared_lat", r_lat, 2);
        check("t6_lock9_cleared", r_st, 0);
        run_txn(0, 2'b00, 6'd21, '0, 1'b0);
        expect_txn("t6_lock21_cleared", 0, 2'b00, 20'd101, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
